// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, valid/ready on both sides.
// GF(2^8) arithmetic, both S-boxes and the key schedule are built from local functions.
module aes_decrypt_iter #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      data_in,
   input  logic [Nk*32-1:0]  key_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      data_decrypted,
   output logic              busy
);
   localparam int NW = 4 * (Nr + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      ROUND = 3'd2,
      FINAL = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                 r_fsm;
   logic [127:0]           r_st;
   logic [127:0]           r_res;
   logic [Nk*32-1:0]       r_key;
   logic [3:0]             r_rnd;
   logic                   r_out_valid;
   logic                   r_busy;

   logic [128*(Nr+1)-1:0]  w_k_sch;
   logic [127:0]           w_rk [0:Nr];
   logic [127:0]           w_inv_core;
   logic [127:0]           w_round_out;
   logic [127:0]           w_final_out;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Full schedule, round 0 in the most significant 128 bits
   function automatic logic [128*(Nr+1)-1:0] key_expand(input logic [Nk*32-1:0] key);
      logic [31:0]           w [NW];
      logic [31:0]           t;
      logic [7:0]            rcon;
      logic [128*(Nr+1)-1:0] ks;
      rcon = 8'h01;
      ks   = '0;
      for (int i = 0; i < NW; i++) begin
         if (i < Nk) begin
            w[i] = key[32*(Nk-i)-1 -: 32];
         end else begin
            t = w[i-1];
            if (i % Nk == 0) begin
               t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
               rcon = xtime(rcon);
            end else if (Nk > 6 && i % Nk == 4) begin
               t = sub_word(t);
            end else begin
               t = w[i-1];
            end
            w[i] = w[i-Nk] ^ t;
         end
         ks[128*(Nr+1)-1-32*i -: 32] = w[i];
      end
      return ks;
   endfunction

   // Byte 4c+r is row r, column c; row r rotates right by r
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++)
         o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a [4];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++)
            a[r] = s[127-8*(4*c+r) -: 8];
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                                    gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
      end
      return o;
   endfunction

   assign w_k_sch = key_expand(r_key);

   for (genvar g = 0; g <= Nr; g++) begin : g_rk
      assign w_rk[g] = w_k_sch[128*(Nr+1-g)-1 -: 128];
   end

   assign w_inv_core  = inv_sub_bytes(inv_shift_rows(r_st));
   assign w_round_out = inv_mix_columns(w_inv_core ^ w_rk[r_rnd]);
   assign w_final_out = w_inv_core ^ w_rk[0];

   assign in_ready       = (r_fsm == IDLE) & ~rst;
   assign out_valid      = r_out_valid;
   assign busy           = r_busy;
   assign data_decrypted = r_res;

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm       <= IDLE;
         r_st        <= 128'd0;
         r_res       <= 128'd0;
         r_key       <= '0;
         r_rnd       <= 4'd0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (in_valid) begin
                  r_st   <= data_in;
                  r_key  <= key_in;
                  r_busy <= 1'b1;
                  r_fsm  <= INIT;
               end
            end
            INIT: begin
               r_st  <= r_st ^ w_rk[Nr];
               r_rnd <= 4'(Nr - 1);
               r_fsm <= ROUND;
            end
            ROUND: begin
               r_st  <= w_round_out;
               r_rnd <= r_rnd - 4'd1;
               if (r_rnd == 4'd1) r_fsm <= FINAL;
            end
            FINAL: begin
               r_res       <= w_final_out;
               r_busy      <= 1'b0;
               r_out_valid <= 1'b1;
               r_fsm       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_fsm       <= IDLE;
               end
            end
            default: begin
               r_fsm       <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors on AES-128/192/256 instances,
// scoreboard on accepted blocks, back-pressure, input churn, mid-block reset, back-to-back.
module tb_aes_decrypt_iter;
   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] data_in, data_decrypted, key_in;
   logic         in_valid6, in_ready6, out_valid6, busy6;
   logic [127:0] data6, dout6;
   logic [191:0] key6;
   logic         in_valid8, in_ready8, out_valid8, busy8;
   logic [127:0] data8, dout8;
   logic [255:0] key8;

   aes_decrypt_iter #(.Nk(4), .Nr(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .key_in(key_in), .out_valid(out_valid), .out_ready(out_ready),
      .data_decrypted(data_decrypted), .busy(busy));
   aes_decrypt_iter #(.Nk(6), .Nr(12)) dut6 (
      .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .data_in(data6),
      .key_in(key6), .out_valid(out_valid6), .out_ready(1'b1),
      .data_decrypted(dout6), .busy(busy6));
   aes_decrypt_iter #(.Nk(8), .Nr(14)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .data_in(data8),
      .key_in(key8), .out_valid(out_valid8), .out_ready(1'b1),
      .data_decrypted(dout8), .busy(busy8));

   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           n_acc = 0;
   int           last_acc = 0;
   int           prev_acc = 0;
   logic [127:0] cur_exp = 128'd0;
   logic [127:0] exp_q [$];
   int           acc_q [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Accept detector: records each accepted block and its expected plaintext
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && in_valid && in_ready) begin
         exp_q.push_back(cur_exp);
         acc_q.push_back(cyc + 1);
         n_acc    <= n_acc + 1;
         prev_acc <= last_acc;
         last_acc <= cyc + 1;
      end
   end

   logic         p_valid = 1'b0, p_hs = 1'b0, p_busy = 1'b0, p_acc = 1'b0;
   logic [127:0] p_data = 128'd0;

   // Output monitor on the AES-128 instance
   always @(negedge clk) begin
      if (rst) begin
         p_valid <= 1'b0; p_hs <= 1'b0; p_busy <= 1'b0; p_acc <= 1'b0;
      end else begin
         if (out_valid && !p_valid) begin
            if (acc_q.size() > 0) check_int("latency", cyc - acc_q.pop_front(), 11);
            else check("spurious_out_valid", out_valid, 1'b0);
         end
         if (p_valid && !p_hs) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", data_decrypted, p_data);
         end
         if (p_hs) begin
            check("valid_one_cycle", out_valid, 1'b0);
            check("idle_after_hs", in_ready, 1'b1);
         end
         if (out_valid) check("in_ready_low_done", in_ready, 1'b0);
         if (busy && !p_busy) check("busy_only_after_accept", p_acc, 1'b1);
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) check("plaintext", data_decrypted, exp_q.pop_front());
            else check("spurious_result", out_valid, 1'b0);
         end
         p_valid <= out_valid;
         p_hs    <= out_valid & out_ready;
         p_data  <= data_decrypted;
         p_busy  <= busy;
         p_acc   <= in_valid & in_ready;
      end
   end

   task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                       input logic hold);
      int n0;
      int t;
      n0 = n_acc;
      t  = 0;
      key_in = k; data_in = c; cur_exp = p; in_valid = 1'b1;
      while (n_acc == n0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (n_acc == n0) check_int("accept_timeout", n_acc, n0 + 1);
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || !in_ready) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check_int("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic run_wide(input int sel, input logic [127:0] req);
      int n;
      n = 0;
      check("wide_in_ready", (sel == 6) ? in_ready6 : in_ready8, 1'b1);
      if (sel == 6) in_valid6 = 1'b1; else in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid6 = 1'b0; in_valid8 = 1'b0;
      while (!((sel == 6) ? out_valid6 : out_valid8) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check_int("wide_latency", n, (sel == 6) ? 13 : 15);
      check("wide_plaintext", (sel == 6) ? dout6 : dout8, req);
      @(posedge clk); #1;
      check("wide_valid_drop", (sel == 6) ? out_valid6 : out_valid8, 1'b0);
   endtask

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [2];
      int   n0;
      int   t;
      logic seen;
      vt[0] = '{key: K1, ct: C1, pt: P1};
      vt[1] = '{key: KB, ct: CB, pt: PB};

      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; data_in = C1; key_in = K1;
      in_valid6 = 1'b0; in_valid8 = 1'b0;
      data6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      key6  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
      data8 = 128'h8ea2b7ca516745bfeafc49904b496089;
      key8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_data", data_decrypted, 128'd0);
      check_int("rst_no_accept", n_acc, 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1 check("in_ready_after_rst", in_ready, 1'b1);

      run_wide(6, P1);
      run_wide(8, P1);

      foreach (vt[i]) begin
         send(vt[i].key, vt[i].ct, vt[i].pt, 1'b0);
         wait_drain();
      end

      // Back-pressure: hold result for 20 cycles
      out_ready = 1'b0;
      send(KB, CB, PB, 1'b0);
      t = 0;
      while (!out_valid && t < 40) begin
         @(posedge clk); #1;
         t++;
      end
      check("bp_valid", out_valid, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      check("bp_data", data_decrypted, PB);
      check("bp_in_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      wait_drain();

      // Inputs churn after accept; in_valid stays high throughout
      send(K1, C1, P1, 1'b1);
      n0   = n_acc;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk); #1;
         if (in_ready) begin
            check_int("no_accept_while_busy", n_acc, n0);
            key_in = KB; data_in = CB; cur_exp = PB;
            seen = 1'b1;
         end else begin
            key_in  = {$urandom, $urandom, $urandom, $urandom};
            data_in = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      check("churn_ready_seen", seen, 1'b1);
      @(posedge clk); #1;
      check_int("second_accept", n_acc, n0 + 1);
      in_valid = 1'b0;
      wait_drain();

      // Reset during ROUND with rnd==5
      send(K1, C1, P1, 1'b0);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_data", data_decrypted, 128'd0);
      check("mid_rst_in_ready", in_ready, 1'b0);
      exp_q.delete();
      acc_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      #1 check("in_ready_after_mid_rst", in_ready, 1'b1);
      repeat (20) @(posedge clk);
      #1 check("no_valid_after_rst", out_valid, 1'b0);
      send(K1, C1, P1, 1'b0);
      wait_drain();

      // Back-to-back with in_valid and out_ready held high
      send(K1, C1, P1, 1'b1);
      send(KB, CB, PB, 1'b0);
      check_int("b2b_spacing", last_acc - prev_acc, 13);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/aes_decrypt_iter.md
# aes_decrypt_iter

Iterative AES inverse-cipher core: accepts one 128-bit ciphertext block and cipher key over a valid/ready handshake and computes one inverse round per clock. It returns the plaintext over a second valid/ready handshake. It is the receive-side counterpart of the combinational `Encryption` core. It reuses the existing `keyExpansion` and `AddRoundKey` blocks plus inverse-round blocks `InvSubBytes`, `InvShiftRows` and `InvMixColumns`.

## Interface
Parameters:
- Nk, default 4, key length in 32-bit words (4/6/8).
- Nr, default 10, round count (10/12/14); must match Nk.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- in_valid  input  1  ciphertext and key present.
- in_ready  output  1  core can accept; equals (fsm==IDLE) & ~rst.
- data_in  input  128  ciphertext, byte 0 in [127:120].
- key_in  input  Nk*32  cipher key, same byte order as `Encryption`.
- out_valid  output  1  data_decrypted holds a new result.
- out_ready  input  1  consumer accepts the result.
- data_decrypted  output  128  plaintext.
- busy  output  1  high in INIT, ROUND and FINAL.

## Operation
- Key schedule:
  - key_reg is captured at accept and feeds `keyExpansion #(Nk,Nr)` combinationally.
  - Round key r (r=0..Nr) is k_sch[128*(Nr+1-r)-1 -: 128]: round 0 at the MSBs, round Nr at [127:0].
- Registers:
  - st (128-bit state)
  - key_reg (Nk*32)
  - rnd (4-bit round counter)
  - fsm
  - res (128-bit, drives data_decrypted)
- FSM:
  - IDLE: on in_valid & in_ready: st<=data_in, key_reg<=key_in -> INIT.
  - INIT: st<=st ^ rk[Nr]; rnd<=Nr-1 -> ROUND.
  - ROUND: st<=InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), rk[rnd])); rnd<=rnd-1. When rnd==1 -> FINAL.
  - FINAL: res<=AddRoundKey(InvSubBytes(InvShiftRows(st)), rk[0]) -> DONE.
  - DONE: out_valid=1. On out_ready -> IDLE.
- in_ready is low in every state except IDLE. data_in/key_in are ignored outside the accept cycle and may change freely afterwards.
- data_decrypted = res. It holds the last result until the next FINAL, and is not updated in INIT or ROUND.
- Inputs are not checked; in_valid while busy is ignored, not queued.
- Unsupported Nk/Nr pairs are illegal; behaviour is undefined.

## Timing
- Reset (async, immediate):
  - fsm=IDLE, out_valid=0, busy=0, in_ready=0 while rst=1.
  - data_decrypted=0; st, key_reg and rnd are cleared.
- Reset asserted mid-operation aborts the block. No out_valid follows. in_ready=1 in the first cycle after rst deasserts.
- Accept edge = E (in_valid & in_ready sampled high).
  - INIT at E+1.
  - ROUND at E+2 .. E+Nr.
  - FINAL at E+Nr+1.
  - out_valid is high after edge E+Nr+1: latency Nr+1 cycles (11 for AES-128, 15 for AES-256).
- out_valid stays high, and data_decrypted stays stable, until out_valid & out_ready is sampled. Indefinite out_ready=0 stalls the core in DONE.
- If out_ready is already high when DONE is entered, handshake completes at the first DONE edge; out_valid is high for exactly one cycle.
- in_ready rises in the cycle after the output handshake. No same-cycle output/input overlap.
- Minimum block period: Nr+3 cycles.
- in_valid asserted during reset is not accepted.

## Test plan
- AES-128, FIPS-197 App. C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1.
  - Required: data_decrypted=00112233445566778899aabbccddeeff, out_valid high exactly 11 cycles after accept, for 1 cycle.
- Nk=6/Nr=12 and Nk=8/Nr=14 instances, key 000102...17 / 000102...1f:
  - data_in dda97ca4864cdfe06eaf70a0ec0d7191 (Nk=6) -> data_decrypted 00112233445566778899aabbccddeeff, latency 13 cycles.
  - data_in 8ea2b7ca516745bfeafc49904b496089 (Nk=8) -> data_decrypted 00112233445566778899aabbccddeeff, latency 15 cycles.
- Back-pressure, FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32, out_ready=0 for 20 cycles.
  - Required: out_valid and data_decrypted=3243f6a8885a308d313198a2e0370734 held stable; in_ready=0 throughout; IDLE the cycle after out_ready=1.
- Input change and ignored requests:
  - Stimulus: change data_in/key_in to random values every cycle after accept; hold in_valid high.
  - Required: C.1 result still correct; second block accepted only when in_ready=1.
- Reset mid-block:
  - Stimulus: assert rst at ROUND rnd=5, asynchronously between edges.
  - Required: out_valid, busy and data_decrypted drop to 0 immediately; no out_valid afterwards; next C.1 block decrypts correctly.
- Back-to-back:
  - Stimulus: C.1 then App. B ciphertext with in_valid and out_ready always high.
  - Required: both results correct; accept-to-accept spacing 13 cycles.
